// File: rtl/idu_gpr_mp_scoreboard_pkg.sv
// Shared types and defaults for the multi-port IDU GPR file and its busy scoreboard.
package idu_gpr_mp_scoreboard_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   gpr_addr_t;
    typedef logic [XLEN_DEF-1:0] gpr_data_t;

    localparam gpr_data_t GPR_ZERO = '0;

    // Register index that may actually be written or tracked: not x0, not past NREG.
    function automatic logic gpr_valid(input int unsigned addr, input int unsigned nreg);
        return (addr != 0) && (addr < nreg);
    endfunction

endpackage

// File: rtl/idu_gpr_mp_scoreboard_gpr_sb_busy.sv
// Per-register busy scoreboard: set on issue, cleared on tagged writeback, wiped on flush.
module gpr_sb_busy
    import idu_gpr_mp_scoreboard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NWR  = 2,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR-1:0]    wr_clr,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Next state: clears first, then the issue set overrides so the new producer keeps the tag.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_clr[w] && gpr_valid(32'(wr_addr[w*AW +: AW]), NREG)) begin
                busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en && gpr_valid(32'(iss_rd), NREG)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/idu_gpr_mp_scoreboard.sv
// Multi-port GPR file (NRD read / NWR write) with busy scoreboard for issue stall logic.
// Optional write-to-read forwarding: define YSYX_23060136_GPR_BYPASS_EN.
module idu_gpr_mp_scoreboard
    import idu_gpr_mp_scoreboard_pkg::*;
#(
    parameter  int XLEN = 64,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      wr_clr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] mem [NREG];

    // Register array; ports are visited in ascending order so the highest index wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= XLEN'(GPR_ZERO);
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && gpr_valid(32'(wr_addr[w*AW +: AW]), NREG)) begin
                    mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    gpr_sb_busy #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW)
    ) u_sb_busy (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wr_en    (wr_en),
        .wr_clr   (wr_clr),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    // Read muxes; x0 and out-of-range addresses read as zero and never busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (gpr_valid(32'(rd_addr[p*AW +: AW]), NREG)) begin
                rd_data[p*XLEN +: XLEN] = mem[rd_addr[p*AW +: AW]];
                rd_busy[p]              = busy_vec[rd_addr[p*AW +: AW]];
`ifdef YSYX_23060136_GPR_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])) begin
                        rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                        rd_busy[p]              = busy_vec[rd_addr[p*AW +: AW]] & ~wr_clr[w];
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_idu_gpr_mp_scoreboard.sv
// Directed, table-driven bench for idu_gpr_mp_scoreboard (NRD=2, NWR=2, XLEN=64, NREG=32).
module tb_idu_gpr_mp_scoreboard;
    import idu_gpr_mp_scoreboard_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [127:0] wr_data;
    logic [1:0]   wr_clr;
    logic         iss_en;
    logic [4:0]   iss_rd;
    logic         flush;
    logic [31:0]  busy_vec;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    idu_gpr_mp_scoreboard #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_clr   (wr_clr),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    typedef struct {
        logic [1:0] wen;
        logic [1:0] wclr;
        gpr_addr_t  wa0, wa1;
        gpr_data_t  wd0, wd1;
        logic       iss;
        gpr_addr_t  ird;
        logic       fl;
        gpr_addr_t  ra0, ra1;
        gpr_data_t  exp0, exp1;
        logic [1:0] expb;
        logic [31:0] expv;
    } vec_t;

    vec_t tbl[17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_clr = '0; iss_en = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        wr_clr = '0; iss_en = 1'b0; iss_rd = '0; flush = 1'b0;

        //         wen    wclr   wa0 wa1 wd0           wd1     iss  ird fl  ra0 ra1 exp0          exp1          expb   expv
        tbl[0]  = '{2'b00, 2'b00, 0,  0,  0,            0,      0,   0,  0,  5,  31, 0,            0,            2'b00, 32'h0};
        tbl[1]  = '{2'b01, 2'b00, 5,  0,  64'hDEADBEEF, 0,      0,   0,  0,  5,  31, 64'hDEADBEEF, 0,            2'b00, 32'h0};
        tbl[2]  = '{2'b01, 2'b00, 0,  0,  64'h1,        0,      0,   0,  0,  0,  5,  0,            64'hDEADBEEF, 2'b00, 32'h0};
        tbl[3]  = '{2'b11, 2'b00, 7,  7,  64'h11,       64'h22, 0,   0,  0,  7,  5,  64'h22,       64'hDEADBEEF, 2'b00, 32'h0};
        tbl[4]  = '{2'b00, 2'b00, 0,  0,  0,            0,      1,   9,  0,  9,  7,  0,            64'h22,       2'b01, 32'h200};
        tbl[5]  = '{2'b10, 2'b10, 0,  9,  0,            64'h99, 0,   0,  0,  9,  7,  64'h99,       64'h22,       2'b00, 32'h0};
        tbl[6]  = '{2'b00, 2'b00, 0,  0,  0,            0,      1,   9,  0,  9,  7,  64'h99,       64'h22,       2'b01, 32'h200};
        tbl[7]  = '{2'b01, 2'b01, 9,  0,  64'hAA,       0,      1,   9,  0,  9,  7,  64'hAA,       64'h22,       2'b01, 32'h200};
        tbl[8]  = '{2'b01, 2'b00, 9,  0,  64'hBB,       0,      0,   0,  0,  9,  7,  64'hBB,       64'h22,       2'b01, 32'h200};
        tbl[9]  = '{2'b00, 2'b00, 0,  0,  0,            0,      1,   3,  0,  9,  3,  64'hBB,       0,            2'b11, 32'h208};
        tbl[10] = '{2'b00, 2'b00, 0,  0,  0,            0,      1,   4,  0,  3,  4,  0,            0,            2'b11, 32'h218};
        tbl[11] = '{2'b00, 2'b00, 0,  0,  0,            0,      1,   6,  1,  9,  6,  64'hBB,       0,            2'b00, 32'h0};
        tbl[12] = '{2'b00, 2'b00, 0,  0,  0,            0,      1,   0,  0,  0,  6,  0,            0,            2'b00, 32'h0};
        tbl[13] = '{2'b00, 2'b00, 0,  0,  0,            0,      1,   8,  0,  8,  10, 0,            0,            2'b01, 32'h100};
        tbl[14] = '{2'b11, 2'b01, 8,  10, 64'h1,        64'h2,  0,   0,  0,  8,  10, 64'h1,        64'h2,        2'b00, 32'h0};
        tbl[15] = '{2'b00, 2'b00, 0,  0,  0,            0,      1,   11, 0,  11, 0,  0,            0,            2'b01, 32'h800};
        tbl[16] = '{2'b11, 2'b01, 11, 11, 64'h5,        64'h6,  0,   0,  0,  11, 0,  64'h6,        0,            2'b00, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wr_en   = tbl[i].wen;  wr_clr = tbl[i].wclr;
            wr_addr = {tbl[i].wa1, tbl[i].wa0};
            wr_data = {tbl[i].wd1, tbl[i].wd0};
            iss_en  = tbl[i].iss;  iss_rd = tbl[i].ird; flush = tbl[i].fl;
            rd_addr = {tbl[i].ra1, tbl[i].ra0};
            @(posedge clk);
            #1 idle();
            #1;
            check($sformatf("v%0d rd_data0", i), 128'(rd_data[63:0]),   128'(tbl[i].exp0));
            check($sformatf("v%0d rd_data1", i), 128'(rd_data[127:64]), 128'(tbl[i].exp1));
            check($sformatf("v%0d rd_busy", i),  128'(rd_busy),         128'(tbl[i].expb));
            check($sformatf("v%0d busy_vec", i), 128'(busy_vec),        128'(tbl[i].expv));
        end

        // Writeback with clear on a busy register that is being read in the same cycle.
        @(negedge clk);
        iss_en = 1'b1; iss_rd = 5'd12; rd_addr = {5'd5, 5'd12};
        @(posedge clk);
        #1 idle();
        #1 check("x12 issued busy_vec", 128'(busy_vec), 128'(32'h1000));
        @(negedge clk);
        wr_en = 2'b01; wr_clr = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {64'h0, 64'h55};
        #1;
`ifdef YSYX_23060136_GPR_BYPASS_EN
        check("x12 same-cycle data", 128'(rd_data[63:0]), 128'(64'h55));
        check("x12 same-cycle busy", 128'(rd_busy[0]), 128'(1'b0));
`else
        check("x12 same-cycle data", 128'(rd_data[63:0]), 128'(64'h0));
        check("x12 same-cycle busy", 128'(rd_busy[0]), 128'(1'b1));
`endif
        check("x5 unaffected by write", 128'(rd_data[127:64]), 128'(64'hDEADBEEF));
        @(posedge clk);
        #1 idle();
        #1;
        check("x12 next data", 128'(rd_data[63:0]), 128'(64'h55));
        check("x12 next busy", 128'(rd_busy[0]), 128'(1'b0));
        check("x12 next busy_vec", 128'(busy_vec), 128'(32'h0));

        // Two ports hitting the register being read: port 1 must be the forwarded value.
        @(negedge clk);
        wr_en = 2'b11; wr_clr = 2'b00; wr_addr = {5'd13, 5'd13};
        wr_data = {64'h88, 64'h77}; rd_addr = {5'd0, 5'd13};
        #1;
`ifdef YSYX_23060136_GPR_BYPASS_EN
        check("x13 same-cycle priority", 128'(rd_data[63:0]), 128'(64'h88));
`else
        check("x13 same-cycle priority", 128'(rd_data[63:0]), 128'(64'h0));
`endif
        @(posedge clk);
        #1 idle();
        #1 check("x13 next data", 128'(rd_data[63:0]), 128'(64'h88));

        // Mid-run reset wipes data and scoreboard; an issue during reset is dropped.
        @(negedge clk);
        iss_en = 1'b1; iss_rd = 5'd14;
        @(negedge clk);
        rst = 1'b1; iss_rd = 5'd15; rd_addr = {5'd13, 5'd5};
        @(posedge clk);
        #1 idle();
        #1;
        check("reset rd_data", rd_data, 128'h0);
        check("reset rd_busy", 128'(rd_busy), 128'h0);
        check("reset busy_vec", 128'(busy_vec), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/idu_gpr_mp_scoreboard.md
Name: idu_gpr_mp_scoreboard

Overview:
Parametrised multi-port general-purpose register file for the IDU, the successor to the single-write / dual-read GPR file.
- Supports NRD read ports and NWR write ports.
- Per-register busy scoreboard: set at instruction issue, cleared at writeback, cleared globally on flush.
- Sits between decode (read/issue) and WBU (write); drives operand-ready information to the issue stall logic.

Parameters:
XLEN, 64, data width of each register
NREG, 32, number of architectural registers; register 0 is hard-wired zero
NRD, 2, number of read ports
NWR, 2, number of write ports; higher index has write priority
AW, $clog2(NREG), register address width (derived, not overridable)

Ports:
clk  input  1  clock
rst  input  1  reset
rd_addr  input  NRD*AW  read addresses, port p at [p*AW +: AW]
rd_data  output  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
rd_busy  output  NRD  port p operand not yet available
wr_en  input  NWR  write strobe per write port
wr_addr  input  NWR*AW  write addresses
wr_data  input  NWR*XLEN  write data
wr_clr  input  NWR  write also clears the busy bit of wr_addr (last writer of that tag)
iss_en  input  1  issue of an instruction with a destination register
iss_rd  input  AW  destination register of the issuing instruction
flush  input  1  pipeline flush: clear all busy bits
busy_vec  output  NREG  current scoreboard state (debug/difftest)

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset state:
  - all registers and all busy bits are 0;
  - rd_data reads 0 and rd_busy is 0 in the cycle after reset.
- Writes take effect at posedge clk.
  - Port w writes only when wr_en[w]=1 and wr_addr≠0.
  - If several ports address the same register in one cycle, the highest-index enabled port wins. There is no error flag.
- Reads are combinational from the register array.
  - Address 0 always returns 0 with rd_busy=0.
  - Out-of-range addresses (≥NREG when NREG is not a power of 2) return 0 with rd_busy=0.
- Scoreboard, updated at posedge and evaluated in this priority order:
  1. rst clears all bits.
  2. flush clears all bits. An iss_en in the same cycle is ignored.
  3. The bit for iss_rd is set when iss_en=1 and iss_rd≠0.
  4. The bit for wr_addr[w] is cleared when wr_en[w]&wr_clr[w]=1, unless that same register is being set by iss_en in the same cycle. Set wins, because the new producer owns the tag.
- wr_en without wr_clr writes data but leaves the busy bit unchanged (older producer in flight).
- Busy bit 0 never sets.
- rd_busy[p] = busy[rd_addr[p]], qualified by the bypass rule below.
- Reset or flush mid-operation: register contents are unaffected by flush; only the scoreboard clears.
- busy_vec reflects the registered scoreboard state, not the same-cycle updates.

Optional Feature:
Macro YSYX_23060136_GPR_BYPASS_EN.
- Defined:
  - write-to-read forwarding. If any enabled write port targets rd_addr[p]≠0 in the current cycle, rd_data[p] takes that port's data, with highest-index priority.
  - rd_busy[p] is 0 if that write also has wr_clr=1.
- Undefined:
  - rd_data shows the pre-write value until the next cycle.
  - rd_busy stays at the registered busy bit.

Decomposition:
- Shared package holds:
  - XLEN, NREG and AW defaults;
  - the typedef gpr_addr_t (logic [AW-1:0]);
  - the typedef gpr_data_t (logic [XLEN-1:0]);
  - the constant GPR_ZERO = 0.
- One sub-module is natural: gpr_sb_busy. It holds the NREG-bit scoreboard register plus the set/clear priority logic, with iss/wr_clr/flush in and busy_vec out.
- The data array, read muxes and bypass live in the top module.

Test Plan:
1. Reset, then read ports 0/1 at x5/x31 -> rd_data=0 and rd_busy=0 on both.
2. Write x5=0xDEAD_BEEF via port 0 in one cycle; read x5 next cycle -> 0xDEADBEEF. Write x0=0x1 -> reads of x0 stay 0.
3. Ports 0 and 1 both write x7, with values 0x11 and 0x22 -> x7=0x22 next cycle.
4. iss_en with iss_rd=9 -> busy_vec[9]=1 and rd_busy=1 for x9. A later wr_en+wr_clr on x9 -> busy clears. The same clear in the same cycle as iss_en with iss_rd=9 -> busy stays 1.
5. Set busy on x3 and x4, then assert flush together with iss_en iss_rd=6 -> busy_vec all 0.
6. With BYPASS_EN, write x12=0x55 with wr_clr while x12 is busy and being read -> same-cycle rd_data=0x55 and rd_busy=0. Without BYPASS_EN -> old value and rd_busy=1 that cycle, then 0x55 and rd_busy=0 next cycle.
